// File: rtl/boot_mem_arbiter_pkg.sv
// Shared types and helpers for the boot-time memory arbiter.
//   arb_state_e : arbitration FSM state (free round-robin or locked to one owner)
//   id_w()      : width of a master index for a given master count
package boot_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width needed to hold a master index 0..n-1 (at least one bit).
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_mem_arbiter_if.sv
// Requester-side bus of the boot memory arbiter, all masters flattened.
//   req_i/lock_i/we_i  : per-master request, lock and write flags
//   addr_i/wdata_i/be_i: flattened per-master fields, master k at [k*W +: W]
//   gnt_o/rvalid_o     : one-hot grant and response valid
//   rdata_o            : response data broadcast to all masters
// The master modport is the requester view, slave is the arbiter view.
interface boot_mem_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]            req_i;
    logic [N_REQ-1:0]            lock_i;
    logic [N_REQ-1:0]            we_i;
    logic [N_REQ*ADDR_W-1:0]     addr_i;
    logic [N_REQ*DATA_W-1:0]     wdata_i;
    logic [N_REQ*DATA_W/8-1:0]   be_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [N_REQ-1:0]            rvalid_o;
    logic [DATA_W-1:0]           rdata_o;

    modport master (
        output req_i, lock_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, lock_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/boot_mem_arbiter_id_fifo.sv
// Synchronous FIFO holding the master index of every granted-but-unanswered
// transaction, so responses can be routed back in grant order.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_id  : enqueue wr_id (ignored when full)
//   pop, rd_id   : dequeue; rd_id is the current head (ignored when empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_id,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] slot_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rd_id     = slot_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            slot_r[wr_ptr_r] <= wr_id;
        end
    end
endmodule

// File: rtl/boot_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory path between N_REQ
// masters (boot loader, debug bridge). A master may lock ownership across a
// multi-beat burst; responses return in order and are routed by an ID FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : requester-side interface (slave modport)
//   mem_req_o ... : winner's request forwarded to the memory
//   mem_gnt_i     : memory accepts the request this cycle
//   mem_rvalid_i  : memory response valid, in request order
//   mem_rdata_i   : memory read data
//   busy_o        : transactions outstanding or ownership locked
//   err_o         : response arrived with nothing outstanding
module boot_mem_arbiter
    import boot_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    boot_mem_arbiter_if.slave    bus,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    output logic [DATA_W/8-1:0]  mem_be_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int IW   = id_w(N_REQ);
    localparam int SW   = IW + 1;
    localparam int CW   = $clog2(MAX_OUT) + 1;
    localparam int BE_W = DATA_W / 8;

    arb_state_e           state_r;
    logic [IW-1:0]        rr_ptr_r;
    logic [IW-1:0]        owner_r;

    logic [N_REQ-1:0]     owner_mask_s;
    logic [N_REQ-1:0]     elig_s;
    logic [2*N_REQ-1:0]   dbl_s;
    logic [N_REQ-1:0]     rot_s;
    logic                 any_s;
    logic [IW-1:0]        off_s;
    logic [SW-1:0]        sum_s;
    logic [IW-1:0]        win_s;
    logic                 mem_req_s;
    logic                 hs_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [IW-1:0]        head_s;
    logic [CW-1:0]        out_cnt_s;
    logic [N_REQ-1:0]     gnt_s;
    logic [N_REQ-1:0]     rvalid_s;
    logic                 unlock_s;

    // Next master index after v, wrapping at N_REQ.
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
        return (int'(v) >= N_REQ - 1) ? '0 : v + IW'(1);
    endfunction

    // Eligibility: everyone in ARB, only the owner while LOCKED.
    always_comb begin
        owner_mask_s          = '0;
        owner_mask_s[owner_r] = 1'b1;
        if (state_r == LOCKED) begin
            elig_s = bus.req_i & owner_mask_s;
        end else begin
            elig_s = bus.req_i;
        end
    end

    // Rotate the eligible set so rr_ptr lands at bit 0, then pick the lowest
    // set bit; the scan down from the top leaves the lowest index in off_s.
    assign dbl_s = {elig_s, elig_s};
    assign rot_s = dbl_s[rr_ptr_r +: N_REQ];
    assign any_s = |rot_s;

    // Priority encoder over the rotated request vector.
    always_comb begin
        off_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IW'(i) : off_s;
        end
    end

    // Undo the rotation: winner = (offset + rr_ptr) mod N_REQ.
    assign sum_s = {1'b0, off_s} + {1'b0, rr_ptr_r};
    assign win_s = (sum_s >= SW'(N_REQ)) ? IW'(sum_s - SW'(N_REQ)) : sum_s[IW-1:0];

    // A full FIFO blocks new requests even if a response pops this cycle.
    assign mem_req_s = any_s & ~fifo_full_s & ~rst;
    assign hs_s      = mem_req_s & mem_gnt_i;
    assign pop_s     = mem_rvalid_i & ~fifo_empty_s & ~rst;
    assign unlock_s  = (hs_s & ~bus.lock_i[owner_r]) |
                       (~bus.req_i[owner_r] & ~bus.lock_i[owner_r]);

    // One-hot grant and response-valid vectors.
    always_comb begin
        gnt_s            = '0;
        gnt_s[win_s]     = hs_s;
        rvalid_s         = '0;
        rvalid_s[head_s] = pop_s;
    end

    assign mem_req_o    = mem_req_s;
    assign mem_we_o     = bus.we_i[win_s];
    assign mem_addr_o   = bus.addr_i[win_s*ADDR_W +: ADDR_W];
    assign mem_wdata_o  = bus.wdata_i[win_s*DATA_W +: DATA_W];
    assign mem_be_o     = bus.be_i[win_s*BE_W +: BE_W];
    assign bus.gnt_o    = gnt_s;
    assign bus.rvalid_o = rvalid_s;
    assign bus.rdata_o  = mem_rdata_i;
    assign busy_o       = ((out_cnt_s != '0) | (state_r == LOCKED)) & ~rst;
    assign err_o        = mem_rvalid_i & fifo_empty_s & ~rst;

    // Arbitration FSM: round-robin pointer update and lock ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB;
            rr_ptr_r <= '0;
            owner_r  <= '0;
        end else begin
            case (state_r)
                ARB: begin
                    if (hs_s && bus.lock_i[win_s]) begin
                        // Pointer stays frozen for the whole locked burst.
                        state_r <= LOCKED;
                        owner_r <= win_s;
                    end else if (hs_s) begin
                        rr_ptr_r <= inc_mod(win_s);
                    end
                end
                LOCKED: begin
                    if (unlock_s) begin
                        state_r  <= ARB;
                        rr_ptr_r <= inc_mod(owner_r);
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (IW)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs_s),
        .wr_id (win_s),
        .pop   (pop_s),
        .rd_id (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (out_cnt_s)
    );
endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed bench for boot_mem_arbiter with two masters and a hand-scripted
// memory target. Each vector is one clock cycle of inputs with the outputs
// expected in that same cycle.
module tb_boot_mem_arbiter;
    localparam int N_REQ  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] lock;
        logic       mg;
        logic       mrv;
        logic [1:0] gnt;
        logic [1:0] rv;
        logic       mreq;
        logic       err;
        logic       busy;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              busy_o;
    logic              err_o;

    int n_checks;
    int n_fail;
    int vec_no;
    vec_t vecs[$];

    logic [31:0] addr_tab [2];
    logic [31:0] wdata_tab [2];
    logic [3:0]  be_tab [2];
    logic        we_tab [2];

    boot_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    boot_mem_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_OUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                                input logic g, input logic v, input logic [1:0] eg,
                                input logic [1:0] erv, input logic emr, input logic ee,
                                input logic eb);
        vec_t t;
        t.rst = r; t.req = rq; t.lock = lk; t.mg = g; t.mrv = v;
        t.gnt = eg; t.rv = erv; t.mreq = emr; t.err = ee; t.busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check mid-cycle, then advance to posedge+1.
    task automatic apply(input vec_t v);
        logic [31:0] rd;
        int          w;
        rd           = 32'hD000_0000 | 32'(vec_no);
        rst          = v.rst;
        bus.req_i    = v.req;
        bus.lock_i   = v.lock;
        mem_gnt_i    = v.mg;
        mem_rvalid_i = v.mrv;
        mem_rdata_i  = rd;
        #4;
        chk("gnt",    vec_no, 32'(bus.gnt_o),    32'(v.gnt));
        chk("rvalid", vec_no, 32'(bus.rvalid_o), 32'(v.rv));
        chk("memreq", vec_no, 32'(mem_req_o),    32'(v.mreq));
        chk("err",    vec_no, 32'(err_o),        32'(v.err));
        chk("busy",   vec_no, 32'(busy_o),       32'(v.busy));
        chk("rdata",  vec_no, bus.rdata_o,       rd);
        if (v.gnt != 2'b00) begin
            w = v.gnt[1] ? 1 : 0;
            chk("addr",  vec_no, mem_addr_o,      addr_tab[w]);
            chk("wdata", vec_no, mem_wdata_o,     wdata_tab[w]);
            chk("be",    vec_no, 32'(mem_be_o),   32'(be_tab[w]));
            chk("we",    vec_no, 32'(mem_we_o),   32'(we_tab[w]));
        end
        @(posedge clk);
        #1;
        vec_no++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec_no   = 0;

        addr_tab[0]  = 32'h0000_1000; addr_tab[1]  = 32'h0000_2000;
        wdata_tab[0] = 32'hA0A0_0000; wdata_tab[1] = 32'hB1B1_1111;
        be_tab[0]    = 4'hF;          be_tab[1]    = 4'h3;
        we_tab[0]    = 1'b0;          we_tab[1]    = 1'b1;

        bus.we_i    = {we_tab[1], we_tab[0]};
        bus.addr_i  = {addr_tab[1], addr_tab[0]};
        bus.wdata_i = {wdata_tab[1], wdata_tab[0]};
        bus.be_i    = {be_tab[1], be_tab[0]};

        //                 rst req    lock   mg    mrv   gnt    rv     mreq  err   busy
        // Reset state
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        // Single master, four reads, response one cycle later
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        // Two masters alternate from rr_ptr=0
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b1,
                              (i % 2 == 0) ? 2'b10 : 2'b01,
                              (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
        // m1 locks for four beats while m0 waits
        vecs.push_back(mk(1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
        // Fill to MAX_OUT without responses, then full-FIFO blocking
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00,
                              (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        // Grants m0,m1,m0 with delayed in-order responses, then a stray response
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        // Target stalls with mem_gnt_i=0, then accepts
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1));

        rst          = 1'b1;
        bus.req_i    = 2'b00;
        bus.lock_i   = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset while LOCKED with two outstanding: lock and IDs must be gone,
        // so a stray response flags err_o and m1 wins despite the old owner m0.
        apply(mk(1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0));
        apply(mk(1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        apply(mk(1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
